// File: rtl/sp3_multi_demux.sv
// rtl/sp3_multi_demux.sv - NCH-channel bit-interleaved MGT word demux with per-channel bitslip
module sp3_multi_demux #(
    parameter int NCH    = 2,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                      mgtclk,
    input  logic                      reset,
    input  logic [WORD_W-1:0]         mgtword_i,
    input  logic                      mgtword_valid_i,
    input  logic [NCH-1:0]            bitslip_i,
    output logic [NCH*WORD_W-1:0]     word_o,
    output logic                      word_valid_o,
    output logic [NCH*CNT_W-1:0]      slip_count_o,
    output logic [$clog2(NCH)-1:0]    phase_o
);

    localparam int SW = WORD_W / NCH;
    localparam int PW = $clog2(NCH);
    localparam int OW = $clog2(WORD_W);
    localparam logic [PW-1:0]    PH_LAST  = PW'(NCH - 1);
    localparam logic [OW-1:0]    OFF_LAST = OW'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    generate
        if (NCH < 2 || (WORD_W % NCH) != 0) begin : g_bad_params
            $error("sp3_multi_demux: NCH must be >= 2 and divide WORD_W");
        end
    endgenerate

    logic [2*WORD_W-1:0] sr       [NCH];
    logic [OW-1:0]       off      [NCH];
    logic [CNT_W-1:0]    cnt      [NCH];
    logic [WORD_W-1:0]   word_q   [NCH];
    logic [NCH-1:0]      pend;

    logic [SW-1:0]       slice    [NCH];
    logic [2*WORD_W-1:0] sr_nxt   [NCH];
    logic [2*WORD_W-1:0] shifted  [NCH];
    logic [OW-1:0]       off_nxt  [NCH];
    logic [WORD_W-1:0]   win      [NCH];
    logic [NCH-1:0]      slip;
    logic                group_done;

    // Window [W-off +: W] of the post-shift register; the new offset already applies.
    always_comb begin
        group_done = mgtword_valid_i && (phase_o == PH_LAST);
        slip       = pend | bitslip_i;
        for (int c = 0; c < NCH; c++) begin
            slice[c] = '0;
            for (int k = 0; k < SW; k++) begin
                slice[c][k] = mgtword_i[k*NCH + c];
            end
            sr_nxt[c] = {slice[c], sr[c][2*WORD_W-1:SW]};
            if (!slip[c]) begin
                off_nxt[c] = off[c];
            end else if (off[c] == OFF_LAST) begin
                off_nxt[c] = '0;
            end else begin
                off_nxt[c] = off[c] + 1'b1;
            end
            shifted[c] = sr_nxt[c] >> (WORD_W - int'(off_nxt[c]));
            win[c]     = shifted[c][WORD_W-1:0];
        end
    end

    always_comb begin
        word_o       = '0;
        slip_count_o = '0;
        for (int c = 0; c < NCH; c++) begin
            word_o[c*WORD_W +: WORD_W]     = word_q[c];
            slip_count_o[c*CNT_W +: CNT_W] = cnt[c];
        end
    end

    always_ff @(posedge mgtclk or posedge reset) begin
        if (reset) begin
            phase_o      <= '0;
            word_valid_o <= 1'b0;
            pend         <= '0;
            for (int c = 0; c < NCH; c++) begin
                sr[c]     <= '0;
                off[c]    <= '0;
                cnt[c]    <= '0;
                word_q[c] <= '0;
            end
        end else begin
            word_valid_o <= group_done;
            if (mgtword_valid_i) begin
                phase_o <= (phase_o == PH_LAST) ? '0 : phase_o + 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
                if (mgtword_valid_i) begin
                    sr[c] <= sr_nxt[c];
                end
                // A request seen on the boundary cycle is consumed there, not carried over.
                if (group_done) begin
                    off[c]    <= off_nxt[c];
                    word_q[c] <= win[c];
                    pend[c]   <= 1'b0;
                    if (slip[c] && cnt[c] != CNT_MAX) begin
                        cnt[c] <= cnt[c] + 1'b1;
                    end
                end else if (bitslip_i[c]) begin
                    pend[c] <= 1'b1;
                end
            end
        end
    end

endmodule
